seven_seg_score_decoder: RTL and testbench
==========================================

// Module: seven_seg_score_decoder
// PURPOSE
//  Receive-side counterpart of the 3-digit multiplexed score display driver: snoops AN/CA scan lines,
//  rebuilds hundreds/tens/ones digits, emits the 8-bit binary score once per complete scan frame.
//  Sits beside the display driver for self-test and for score readback; same 100 MHz clk domain.
// PARAMETERS
//  SETTLE_CYC   16       consecutive cycles AN/CA must be unchanged before a slot is captured (>=2)
//  TIMEOUT_CYC  8192     max cycles between valid frames before timeout (SEG_TIMEOUT_EN only)
// PORTS
//  clk          in   1  100 MHz system clock; all logic on posedge
//  rst          in   1  asynchronous, active-high reset
//  AN           in   4  anodes, active-low; 1011=hundreds, 1101=tens, 1110=ones, 1111=blank
//  CA           in   7  cathodes {g..a}, active-low segment patterns
//  score        out  8  last successfully decoded score, binary
//  score_valid  out  1  1-cycle pulse: score updated this cycle
//  digit_err    out  1  1-cycle pulse: captured CA is not a digit pattern 0-9
//  frame_err    out  1  1-cycle pulse: slot order violated or illegal AN pattern
//  range_err    out  1  1-cycle pulse: complete frame decodes to value > 255
//  timeout      out  1  level; only present/driven when SEG_TIMEOUT_EN defined, else tied 0
// BEHAVIOUR
//  - Reset: score=0, all pulses 0, timeout=0, FSM=WAIT_H, stable_cnt=0, captured=0, digit regs=0.
//  - AN/CA are same-domain, sampled directly (no synchroniser); previous-cycle copies held in regs.
//  - Settle: stable_cnt clears when {AN,CA} differs from previous cycle, else increments, saturating
//    at SETTLE_CYC. Slot captured on the cycle stable_cnt reaches SETTLE_CYC-1 (once per dwell;
//    'captured' flag set, cleared on any AN/CA change). Shorter dwells are ignored entirely.
//  - AN=1111 is a blank slot: never captured, no FSM effect. Any AN other than the four listed
//    patterns, once settled -> frame_err pulse, FSM -> WAIT_H.
//  - CA decode (active-low): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//    6=0000010 7=1111000 8=0000000 9=0010000; anything else -> digit_err pulse, FSM -> WAIT_H.
//  - FSM on each valid capture: WAIT_H: hundreds->GOT_H (store d2), tens/ones ignored (resync).
//    GOT_H: tens->GOT_T (store d1); hundreds->re-store d2, stay; ones->frame_err, WAIT_H.
//    GOT_T: ones->store d0, compute; hundreds->GOT_H (restart with new d2); tens->frame_err, WAIT_H.
//  - Compute: 10-bit sum d2*100+d1*10+d0 (shift-add, no divider). Registered on edge after ones
//    capture: if <=255 score<=sum[7:0], score_valid=1; else range_err=1, score held. FSM -> WAIT_H.
//  - Latency: score_valid asserts SETTLE_CYC cycles after AN/CA switch to the ones slot.
//  - Error and valid pulses are mutually exclusive per cycle; score changes only with score_valid.
//  - Reset mid-frame: all state discarded immediately; first valid needs a fresh H,T,O sequence.
// CONFIGURATION
//  SEG_TIMEOUT_EN defined: free counter clears on score_valid, saturates at TIMEOUT_CYC; timeout=1
//   while saturated, drops the cycle after next score_valid. Not defined: no counter, timeout=0.
// STRUCTURE
//  - Package seven_seg_pkg: AN slot constants (AN_HUND/AN_TENS/AN_ONES/AN_BLANK), CA digit pattern
//    table, FSM state encoding; shared with the display driver so both ends use one table.
//  - Sub-module seg_pattern_decode: combinational CA[6:0] -> {digit[3:0], is_digit}.
//  - Top: settle counter, capture flag, FSM, digit regs, score arithmetic, optional watchdog.
// TESTING
//  1. Drive 137 (AN 1011/CA 1111001, 1101/0110000, 1110/1111000, 1000 cyc each) -> score=137,
//     one score_valid per frame, SETTLE_CYC cycles into ones slot.
//  2. Insert 5-cycle glitch AN=1110/CA=0000000 inside tens slot -> ignored, score=137 still valid.
//  3. Tens slot CA=1111111 -> digit_err pulse, no score_valid that frame, score holds previous.
//  4. Frames 2,5,5 then 2,5,6 -> score=255 valid, then range_err pulse, score stays 255.
//  5. Order H,O,T -> frame_err at ones capture; next clean frame 042 -> score=42 valid.
//  6. Assert rst during tens slot -> score=0 immediately; resumes only after full new frame.
//     With SEG_TIMEOUT_EN, TIMEOUT_CYC=64 and AN held 1111 -> timeout=1 after 64 cycles.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared AN slot codes, CA digit table and decoder FSM states
package seven_seg_pkg;

    localparam logic [3:0] AN_HUND  = 4'b1011;
    localparam logic [3:0] AN_TENS  = 4'b1101;
    localparam logic [3:0] AN_ONES  = 4'b1110;
    localparam logic [3:0] AN_BLANK = 4'b1111;

    // Active-low {g..a} pattern for digits 0..9, indexed by digit value
    localparam logic [6:0] CA_DIGIT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef enum logic [1:0] {
        WAIT_H = 2'd0,
        GOT_H  = 2'd1,
        GOT_T  = 2'd2
    } seg_state_e;

    // d2*100 + d1*10 + d0 using shifts only
    function automatic logic [9:0] bcd3_to_bin(input logic [3:0] d2,
                                               input logic [3:0] d1,
                                               input logic [3:0] d0);
        logic [9:0] h;
        logic [9:0] t;
        logic [9:0] o;
        h = {6'b0, d2};
        t = {6'b0, d1};
        o = {6'b0, d0};
        return (h << 6) + (h << 5) + (h << 2) + (t << 3) + (t << 1) + o;
    endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - combinational CA pattern to digit lookup
module seg_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] ca_i,
    output logic [3:0] digit_o,
    output logic       is_digit_o
);

    always_comb begin
        digit_o    = '0;
        is_digit_o = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (ca_i == CA_DIGIT[i]) begin
                digit_o    = 4'(i);
                is_digit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg_score_decoder.sv
// rtl/seven_seg_score_decoder.sv - rebuilds the 3-digit score from snooped AN/CA scan lines
// Optional frame watchdog enabled by defining SEG_TIMEOUT_EN.
module seven_seg_score_decoder
    import seven_seg_pkg::*;
#(
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 8192
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] AN,
    input  logic [6:0] CA,
    output logic [7:0] score,
    output logic       score_valid,
    output logic       digit_err,
    output logic       frame_err,
    output logic       range_err,
    output logic       timeout
);

    localparam int CW = $clog2(SETTLE_CYC + 1);

    logic [3:0]    an_prev_q;
    logic [6:0]    ca_prev_q;
    logic [CW-1:0] stable_cnt_q, stable_cnt_d;
    logic          captured_q, captured_d;
    seg_state_e    state_q, state_d;
    logic [3:0]    d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
    logic          compute_q, compute_d;
    logic [7:0]    score_q, score_d;
    logic          score_valid_q, score_valid_d;
    logic          digit_err_q, digit_err_d;
    logic          frame_err_q, frame_err_d;
    logic          range_err_q, range_err_d;

    logic          changed;
    logic          capture;
    logic [3:0]    digit;
    logic          is_digit;
    logic [9:0]    sum;

    seg_pattern_decode u_decode (
        .ca_i       (CA),
        .digit_o    (digit),
        .is_digit_o (is_digit)
    );

    assign changed = (AN != an_prev_q) || (CA != ca_prev_q);
    // Fires on the cycle the count would reach SETTLE_CYC-1, so the slot register lands one edge earlier
    assign capture = !changed && !captured_q && (stable_cnt_q == CW'(SETTLE_CYC - 2));
    assign sum     = bcd3_to_bin(d2_q, d1_q, d0_q);

    always_comb begin
        stable_cnt_d  = stable_cnt_q;
        captured_d    = captured_q;
        state_d       = state_q;
        d2_d          = d2_q;
        d1_d          = d1_q;
        d0_d          = d0_q;
        compute_d     = 1'b0;
        score_d       = score_q;
        score_valid_d = 1'b0;
        digit_err_d   = 1'b0;
        frame_err_d   = 1'b0;
        range_err_d   = 1'b0;

        if (changed) begin
            stable_cnt_d = '0;
            captured_d   = 1'b0;
        end else begin
            if (stable_cnt_q != CW'(SETTLE_CYC)) stable_cnt_d = stable_cnt_q + 1'b1;
            if (capture) captured_d = 1'b1;
        end

        if (compute_q) begin
            if (sum <= 10'd255) begin
                score_d       = sum[7:0];
                score_valid_d = 1'b1;
            end else begin
                range_err_d = 1'b1;
            end
        end

        if (capture) begin
            case (AN)
                AN_BLANK: ;
                AN_HUND, AN_TENS, AN_ONES: begin
                    if (!is_digit) begin
                        digit_err_d = 1'b1;
                        state_d     = WAIT_H;
                    end else begin
                        case (state_q)
                            WAIT_H: begin
                                if (AN == AN_HUND) begin
                                    d2_d    = digit;
                                    state_d = GOT_H;
                                end
                            end
                            GOT_H: begin
                                if (AN == AN_TENS) begin
                                    d1_d    = digit;
                                    state_d = GOT_T;
                                end else if (AN == AN_HUND) begin
                                    d2_d = digit;
                                end else begin
                                    frame_err_d = 1'b1;
                                    state_d     = WAIT_H;
                                end
                            end
                            GOT_T: begin
                                if (AN == AN_ONES) begin
                                    d0_d      = digit;
                                    compute_d = 1'b1;
                                    state_d   = WAIT_H;
                                end else if (AN == AN_HUND) begin
                                    d2_d    = digit;
                                    state_d = GOT_H;
                                end else begin
                                    frame_err_d = 1'b1;
                                    state_d     = WAIT_H;
                                end
                            end
                            default: state_d = WAIT_H;
                        endcase
                    end
                end
                default: begin
                    frame_err_d = 1'b1;
                    state_d     = WAIT_H;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_prev_q     <= AN_BLANK;
            ca_prev_q     <= 7'h7F;
            stable_cnt_q  <= '0;
            captured_q    <= 1'b0;
            state_q       <= WAIT_H;
            d2_q          <= '0;
            d1_q          <= '0;
            d0_q          <= '0;
            compute_q     <= 1'b0;
            score_q       <= '0;
            score_valid_q <= 1'b0;
            digit_err_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            range_err_q   <= 1'b0;
        end else begin
            an_prev_q     <= AN;
            ca_prev_q     <= CA;
            stable_cnt_q  <= stable_cnt_d;
            captured_q    <= captured_d;
            state_q       <= state_d;
            d2_q          <= d2_d;
            d1_q          <= d1_d;
            d0_q          <= d0_d;
            compute_q     <= compute_d;
            score_q       <= score_d;
            score_valid_q <= score_valid_d;
            digit_err_q   <= digit_err_d;
            frame_err_q   <= frame_err_d;
            range_err_q   <= range_err_d;
        end
    end

    assign score       = score_q;
    assign score_valid = score_valid_q;
    assign digit_err   = digit_err_q;
    assign frame_err   = frame_err_q;
    assign range_err   = range_err_q;

`ifdef SEG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wd_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q <= '0;
        end else if (score_valid_q) begin
            wd_cnt_q <= '0;
        end else if (wd_cnt_q != TW'(TIMEOUT_CYC)) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end

    assign timeout = (wd_cnt_q == TW'(TIMEOUT_CYC));
`else
    logic [31:0] unused_timeout_cyc;
    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_seven_seg_score_decoder.sv
// tb/tb_seven_seg_score_decoder.sv - self-checking bench for seven_seg_score_decoder
module tb_seven_seg_score_decoder;

    localparam int S = 16;
`ifdef SEG_TIMEOUT_EN
    localparam int TO = 64;
`else
    localparam int TO = 8192;
`endif
    localparam logic [3:0] H = 4'b1011, T = 4'b1101, O = 4'b1110, B = 4'b1111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] AN  = 4'b1111;
    logic [6:0] CA  = 7'h7F;
    logic [7:0] score;
    logic       score_valid, digit_err, frame_err, range_err, timeout;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, n_valid = 0, n_derr = 0, n_ferr = 0, n_rerr = 0;
    int last_valid_cyc = 0, ones_sw_cyc = 0, n_multi = 0, n_bad_change = 0;
    logic [7:0] prev_score = 8'd0;

    seven_seg_score_decoder #(.SETTLE_CYC(S), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .AN(AN), .CA(CA), .score(score), .score_valid(score_valid),
        .digit_err(digit_err), .frame_err(frame_err), .range_err(range_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (score_valid) begin n_valid++; last_valid_cyc = cyc; end
        if (digit_err) n_derr++;
        if (frame_err) n_ferr++;
        if (range_err) n_rerr++;
        if (int'(score_valid) + int'(digit_err) + int'(frame_err) + int'(range_err) > 1) n_multi++;
        if (!rst && score !== prev_score && !score_valid) n_bad_change++;
        prev_score = score;
    end

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
            3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    task automatic slot(input logic [3:0] an, input logic [6:0] ca, input int n);
        AN = an;
        CA = ca;
        if (an == O) ones_sw_cyc = cyc + 1;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input int h, input int t, input int o, input int n);
        slot(H, enc(h), n);
        slot(T, enc(t), n);
        slot(O, enc(o), n);
        slot(B, 7'h7F, 4);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++; if (score !== 8'd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", score); end
        n_checks++; if ({score_valid, digit_err, frame_err, range_err, timeout} !== 5'b0) begin
            n_fail++; $display("FAIL reset_pulses: got %b expected 00000", {score_valid, digit_err, frame_err, range_err, timeout}); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        int v0, e0;
        v0 = n_valid; e0 = n_derr + n_ferr + n_rerr;
        frame(1, 3, 7, 1000);
        n_checks++; if (score !== 8'd137) begin n_fail++; $display("FAIL basic_score: got %0d expected 137", score); end
        n_checks++; if (n_valid - v0 != 1) begin n_fail++; $display("FAIL basic_valid_count: got %0d expected 1", n_valid - v0); end
        n_checks++; if (last_valid_cyc - ones_sw_cyc != S) begin
            n_fail++; $display("FAIL basic_latency: got %0d expected %0d", last_valid_cyc - ones_sw_cyc, S); end
        n_checks++; if (n_derr + n_ferr + n_rerr != e0) begin n_fail++; $display("FAIL basic_no_err: got %0d expected %0d", n_derr + n_ferr + n_rerr, e0); end
        v0 = n_valid;
        frame(1, 3, 7, 100);
        n_checks++; if (n_valid - v0 != 1) begin n_fail++; $display("FAIL basic_second_frame: got %0d expected 1", n_valid - v0); end
    endtask

    task automatic test_glitch;
        int v0, e0;
        v0 = n_valid; e0 = n_derr + n_ferr + n_rerr;
        slot(H, enc(1), 100);
        slot(T, enc(3), 5);
        slot(O, enc(8), 5);
        slot(T, enc(3), 100);
        slot(O, enc(7), 100);
        slot(B, 7'h7F, 4);
        n_checks++; if (n_valid - v0 != 1 || score !== 8'd137) begin
            n_fail++; $display("FAIL glitch_valid: got %0d valids score %0d expected 1 valid score 137", n_valid - v0, score); end
        n_checks++; if (n_derr + n_ferr + n_rerr != e0) begin n_fail++; $display("FAIL glitch_no_err: got %0d expected %0d", n_derr + n_ferr + n_rerr, e0); end
    endtask

    task automatic test_digit_err;
        int v0, d0;
        v0 = n_valid; d0 = n_derr;
        slot(H, enc(1), 100);
        slot(T, 7'b1111111, 100);
        slot(O, enc(7), 100);
        slot(B, 7'h7F, 4);
        n_checks++; if (n_derr - d0 != 1) begin n_fail++; $display("FAIL digit_err_pulse: got %0d expected 1", n_derr - d0); end
        n_checks++; if (n_valid != v0) begin n_fail++; $display("FAIL digit_err_no_valid: got %0d expected 0", n_valid - v0); end
        n_checks++; if (score !== 8'd137) begin n_fail++; $display("FAIL digit_err_hold: got %0d expected 137", score); end
    endtask

    task automatic test_range;
        int v0, r0;
        v0 = n_valid; r0 = n_rerr;
        frame(2, 5, 5, 100);
        n_checks++; if (score !== 8'd255 || n_valid - v0 != 1) begin
            n_fail++; $display("FAIL range_255: got score %0d valids %0d expected 255 and 1", score, n_valid - v0); end
        v0 = n_valid;
        frame(2, 5, 6, 100);
        n_checks++; if (n_rerr - r0 != 1) begin n_fail++; $display("FAIL range_err_pulse: got %0d expected 1", n_rerr - r0); end
        n_checks++; if (score !== 8'd255 || n_valid != v0) begin
            n_fail++; $display("FAIL range_hold: got score %0d valids %0d expected 255 and 0", score, n_valid - v0); end
    endtask

    task automatic test_order;
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        slot(H, enc(1), 100);
        slot(O, enc(2), 100);
        slot(T, enc(3), 100);
        slot(B, 7'h7F, 4);
        n_checks++; if (n_ferr - f0 != 1 || n_valid != v0) begin
            n_fail++; $display("FAIL order_frame_err: got ferr %0d valids %0d expected 1 and 0", n_ferr - f0, n_valid - v0); end
        f0 = n_ferr;
        slot(H, enc(4), 100);
        slot(4'b0111, enc(4), 100);
        slot(B, 7'h7F, 4);
        n_checks++; if (n_ferr - f0 != 1) begin n_fail++; $display("FAIL illegal_an: got %0d expected 1", n_ferr - f0); end
        v0 = n_valid;
        frame(0, 4, 2, 100);
        n_checks++; if (score !== 8'd42 || n_valid - v0 != 1) begin
            n_fail++; $display("FAIL order_recover: got score %0d valids %0d expected 42 and 1", score, n_valid - v0); end
    endtask

    task automatic test_reset_mid_frame;
        int v0;
        slot(H, enc(1), 100);
        AN = T; CA = enc(2);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (score !== 8'd0) begin n_fail++; $display("FAIL reset_mid_score: got %0d expected 0", score); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        v0 = n_valid;
        repeat (70) @(negedge clk);
        slot(O, enc(3), 100);
        slot(B, 7'h7F, 4);
        n_checks++; if (n_valid != v0 || score !== 8'd0) begin
            n_fail++; $display("FAIL reset_mid_no_valid: got valids %0d score %0d expected 0 and 0", n_valid - v0, score); end
        frame(1, 2, 3, 100);
        n_checks++; if (score !== 8'd123 || n_valid - v0 != 1) begin
            n_fail++; $display("FAIL reset_mid_resume: got score %0d valids %0d expected 123 and 1", score, n_valid - v0); end
    endtask

    task automatic test_random;
        int h, t, o, n, v, v0, r0;
        logic [7:0] exp_score;
        exp_score = score;
        for (int k = 0; k < 20; k++) begin
            h = $urandom_range(0, 2); t = $urandom_range(0, 9); o = $urandom_range(0, 9);
            n = $urandom_range(S + 2, S + 40);
            v = h * 100 + t * 10 + o;
            v0 = n_valid; r0 = n_rerr;
            frame(h, t, o, n);
            if (v <= 255) exp_score = 8'(v);
            n_checks++; if (score !== exp_score) begin n_fail++; $display("FAIL random_score[%0d]: got %0d expected %0d", k, score, exp_score); end
            n_checks++; if (n_valid - v0 != (v <= 255 ? 1 : 0) || n_rerr - r0 != (v > 255 ? 1 : 0)) begin
                n_fail++; $display("FAIL random_pulses[%0d]: got valid %0d range %0d for value %0d", k, n_valid - v0, n_rerr - r0, v); end
        end
    endtask

    task automatic test_timeout;
`ifdef SEG_TIMEOUT_EN
        int vc;
        slot(H, enc(0), 40);
        slot(T, enc(0), 40);
        slot(O, enc(9), S + 2);
        AN = B; CA = 7'h7F;
        vc = last_valid_cyc;
        while (cyc < vc + 30) @(negedge clk);
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b expected 0", timeout); end
        while (cyc < vc + 70) @(negedge clk);
        n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_set: got %b expected 1", timeout); end
        frame(0, 0, 1, 40);
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b expected 0", timeout); end
`else
        slot(B, 7'h7F, 200);
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_tied: got %b expected 0", timeout); end
`endif
    endtask

    task automatic test_invariants;
        n_checks++; if (n_multi != 0) begin n_fail++; $display("FAIL pulse_exclusive: got %0d overlaps expected 0", n_multi); end
        n_checks++; if (n_bad_change != 0) begin n_fail++; $display("FAIL score_change_without_valid: got %0d expected 0", n_bad_change); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_basic;
        test_glitch;
        test_digit_err;
        test_range;
        test_order;
        test_reset_mid_frame;
        test_random;
        test_timeout;
        test_invariants;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
